wave_slot_scheduler: RTL and testbench

WAVE_SLOT_SCHEDULER -- requirements
Module: wave_slot_scheduler

---
 rtl/wave_slot_scheduler.sv | 124 ++++++++++++
 tb/tb_wave_slot_scheduler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wave_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : wave_slot_scheduler
//  Description : Round-robin time-slot arbiter that hands a shared PWM output
//                to one of four waveform sources (square, sawtooth, triangle,
//                constant-half) for CYCLES_PER_GRANT full waveform cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module wave_slot_scheduler #(
  parameter int unsigned CYCLES_PER_GRANT = 1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [3:0] Enable_SW,
  output logic [3:0] Grant,
  output logic [6:0] Duty_Cycle,
  output logic       Pulse,
  output logic       Busy,
  output logic       Done
);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_run    = 1'b1;
  localparam logic [3:0] c_last_slot = 4'(CYCLES_PER_GRANT - 1);

  logic [0:0] r_state;
  logic [5:0] r_cnt;
  logic [5:0] r_idx;
  logic [3:0] r_slot;
  logic [1:0] r_last;
  logic [3:0] r_grant;

  logic       w_win_valid;
  logic [1:0] w_win_idx;
  logic       w_wce;
  logic       w_se;
  logic [6:0] w_duty;

  // Round-robin winner: the lowest k in 1..4 with Enable_SW[last+k] set wins,
  // so the loop runs from k=4 down and the final overwrite has priority.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = r_last;
    for (int k = 4; k >= 1; k--) begin
      if (Enable_SW[r_last + 2'(k)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = r_last + 2'(k);
      end
    end
  end

  // Waveform-cycle end and slot end, decoded straight from the registers.
  assign w_wce = (r_state == c_st_run) && (r_cnt == 6'd63) && (r_idx == 6'd63);
  assign w_se  = w_wce && (r_slot == c_last_slot);

  // Duty value chosen by the current owner's waveform at phase index idx.
  always_comb begin
    w_duty = 7'd0;
    case (r_grant)
      4'b0001: w_duty = ((r_idx >= 6'd16) && (r_idx <= 6'd47)) ? 7'd64 : 7'd0;
      4'b0010: w_duty = {1'b0, r_idx};
      4'b0100: w_duty = (r_idx < 6'd32) ? {r_idx, 1'b0} : {(6'd63 - r_idx), 1'b1};
      4'b1000: w_duty = 7'd32;
      default: w_duty = 7'd0;
    endcase
  end

  // Scheduler state: PWM/phase/slot counters, ownership and round-robin pointer.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_cnt   <= 6'd0;
      r_idx   <= 6'd0;
      r_slot  <= 4'd0;
      r_last  <= 2'd3;
      r_grant <= 4'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          r_cnt  <= 6'd0;
          r_idx  <= 6'd0;
          r_slot <= 4'd0;
          if (w_win_valid) begin
            r_state <= c_st_run;
            r_grant <= 4'b0001 << w_win_idx;
            r_last  <= w_win_idx;
          end else begin
            r_grant <= 4'd0;
          end
        end
        default: begin
          // cnt and idx wrap naturally to 0 at slot end, so the next slot
          // starts on the following clock with no gap.
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_idx <= r_idx + 6'd1;
          end
          if (w_wce) begin
            if (w_se) begin
              r_slot <= 4'd0;
              if (w_win_valid) begin
                r_grant <= 4'b0001 << w_win_idx;
                r_last  <= w_win_idx;
              end else begin
                r_state <= c_st_idle;
                r_grant <= 4'd0;
              end
            end else begin
              r_slot <= r_slot + 4'd1;
            end
          end
        end
      endcase
    end
  end

  assign Grant      = r_grant;
  assign Busy       = (r_state == c_st_run);
  assign Done       = w_se;
  assign Duty_Cycle = w_duty;
  assign Pulse      = Busy && ({1'b0, r_cnt} < w_duty);

endmodule
`default_nettype wire

// File: tb/tb_wave_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_slot_scheduler
//  Description : Self-checking bench for wave_slot_scheduler. Two instances
//                (one and two waveform cycles per grant) share all stimulus
//                and are compared every clock against a slot-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_slot_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic [3:0] grant [2];
  logic [6:0] duty  [2];
  logic       pulse [2];
  logic       busy  [2];
  logic       done  [2];

  int n_checks;
  int n_errors;

  // Model state per instance: running flag, owner index (-1 none),
  // round-robin pointer and clocks elapsed inside the current slot.
  int m_busy  [2];
  int m_owner [2];
  int m_ptr   [2];
  int m_t     [2];
  int m_cyc   [2];

  wave_slot_scheduler #(.CYCLES_PER_GRANT(1)) u_dut0 (
    .sysclk(clk), .rst(rst), .Enable_SW(en), .Grant(grant[0]),
    .Duty_Cycle(duty[0]), .Pulse(pulse[0]), .Busy(busy[0]), .Done(done[0])
  );

  wave_slot_scheduler #(.CYCLES_PER_GRANT(2)) u_dut1 (
    .sysclk(clk), .rst(rst), .Enable_SW(en), .Grant(grant[1]),
    .Duty_Cycle(duty[1]), .Pulse(pulse[1]), .Busy(busy[1]), .Done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int duty_of(input int owner, input int idx);
    case (owner)
      0:       return (idx >= 16 && idx <= 47) ? 64 : 0;
      1:       return idx;
      2:       return (idx < 32) ? 2 * idx : 2 * (63 - idx) + 1;
      3:       return 32;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i]  = 0;
      m_owner[i] = -1;
      m_ptr[i]   = 3;
      m_t[i]     = 0;
    end
  endtask

  task automatic model_clock();
    int w;
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] == 0) begin
        w = pick(m_ptr[i], en);
        if (w >= 0) begin
          m_busy[i] = 1; m_owner[i] = w; m_ptr[i] = w; m_t[i] = 0;
        end
      end else if (m_t[i] == 4096 * m_cyc[i] - 1) begin
        w = pick(m_ptr[i], en);
        if (w >= 0) begin
          m_owner[i] = w; m_ptr[i] = w; m_t[i] = 0;
        end else begin
          m_busy[i] = 0; m_owner[i] = -1; m_t[i] = 0;
        end
      end else begin
        m_t[i]++;
      end
    end
  endtask

  task automatic check_all();
    int cnt, idx, d, g, p, dn;
    for (int i = 0; i < 2; i++) begin
      cnt = m_t[i] % 64;
      idx = (m_t[i] / 64) % 64;
      d   = m_busy[i] ? duty_of(m_owner[i], idx) : 0;
      g   = (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
      p   = (m_busy[i] != 0 && cnt < d) ? 1 : 0;
      dn  = (m_busy[i] != 0 && m_t[i] == 4096 * m_cyc[i] - 1) ? 1 : 0;
      chk($sformatf("u%0d.grant", i), int'(grant[i]), g);
      chk($sformatf("u%0d.duty",  i), int'(duty[i]),  d);
      chk($sformatf("u%0d.pulse", i), int'(pulse[i]), p);
      chk($sformatf("u%0d.busy",  i), int'(busy[i]),  m_busy[i]);
      chk($sformatf("u%0d.done",  i), int'(done[i]),  dn);
    end
  endtask

  // Advance n clocks; outputs are compared on each falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_clock();
      @(negedge clk);
      check_all();
    end
  endtask

  // Assert reset between edges, confirm outputs clear immediately, hold it
  // for two clocks, then release on a falling edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int len;
    n_checks = 0;
    n_errors = 0;
    m_cyc[0] = 1;
    m_cyc[1] = 2;
    rst = 1'b1;
    en  = 4'b0000;
    model_reset();
    @(negedge clk);
    check_all();
    run(2);
    rst = 1'b0;

    // Directed scenarios
    en = 4'b0001; run(4300);
    en = 4'b0010; run(4200);
    en = 4'b0100; run(4200);
    en = 4'b0110; run(8300);
    en = 4'b1111; run(33000);

    async_reset();
    en = 4'b0001; run(1000);
    en = 4'b0000; run(9000);

    async_reset();
    en = 4'b0100; run(2000);
    async_reset();
    en = 4'b1000; run(4200);

    // Randomized segments with mid-slot request churn and occasional resets
    for (int s = 0; s < 10; s++) begin
      en  = 4'($urandom);
      len = int'($urandom_range(200, 1000));
      for (int c = 0; c < len; c++) begin
        run(1);
        if ($urandom_range(0, 199) == 0) en = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
